// File: rtl/lake_pkg.sv
// Shared types for the load/store unit: bus access formats (funct3 encoding)
// and the transaction FSM states.
package lake_pkg;

  typedef enum logic [2:0] {
    FMT_B  = 3'b000,
    FMT_H  = 3'b001,
    FMT_W  = 3'b010,
    FMT_BU = 3'b100,
    FMT_HU = 3'b101
  } bus_fmt_e;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } lsu_state_e;

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: store strobe/data placement, load byte/halfword
// extraction with sign or zero extension, and request legality checking.
module lsu_align
  import lake_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      st_fmt_i,
  input  logic [1:0]      st_lo_i,
  input  logic [XLEN-1:0] st_data_i,
  input  logic            r_en_i,
  input  logic            w_en_i,
  output logic [3:0]      wstrb_o,
  output logic [XLEN-1:0] wdata_o,
  output logic            bad_o,
  input  logic [2:0]      ld_fmt_i,
  input  logic [1:0]      ld_lo_i,
  input  logic [XLEN-1:0] ld_word_i,
  output logic [XLEN-1:0] ld_data_o
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  assign ld_byte = ld_word_i[{ld_lo_i, 3'b000} +: 8];
  assign ld_half = ld_word_i[{ld_lo_i[1], 4'b0000} +: 16];

  always_comb begin
    wstrb_o = 4'b0000;
    wdata_o = st_data_i;
    bad_o   = r_en_i & w_en_i;
    case (st_fmt_i)
      FMT_B, FMT_BU: begin
        wstrb_o = 4'b0001 << st_lo_i;
        wdata_o = {(XLEN/8){st_data_i[7:0]}};
      end
      FMT_H, FMT_HU: begin
        wstrb_o = 4'b0011 << st_lo_i;
        wdata_o = {(XLEN/16){st_data_i[15:0]}};
        if (st_lo_i[0]) bad_o = 1'b1;
      end
      FMT_W: begin
        wstrb_o = 4'b1111;
        if (st_lo_i != 2'b00) bad_o = 1'b1;
      end
      default: bad_o = 1'b1;
    endcase
  end

  always_comb begin
    ld_data_o = ld_word_i;
    case (ld_fmt_i)
      FMT_B:   ld_data_o = {{(XLEN-8){ld_byte[7]}}, ld_byte};
      FMT_BU:  ld_data_o = {{(XLEN-8){1'b0}}, ld_byte};
      FMT_H:   ld_data_o = {{(XLEN-16){ld_half[15]}}, ld_half};
      FMT_HU:  ld_data_o = {{(XLEN-16){1'b0}}, ld_half};
      default: ld_data_o = ld_word_i;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// Load/store unit: single-outstanding valid/ready data-bus transaction with
// word-aligned addressing, byte strobes, extended load data and timeout fault.
module lsu
  import lake_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 255
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic [2:0]      i_bus_fmt,
  input  logic            i_bus_r_en,
  input  logic            i_bus_w_en,
  input  logic [XLEN-1:0] i_addr,
  input  logic [XLEN-1:0] i_wdata,
  output logic [XLEN-1:0] o_rdata,
  output logic            o_done,
  output logic            o_fault,
  output logic            o_stall,
  output logic            o_bus_valid,
  output logic            o_bus_we,
  output logic [XLEN-1:0] o_bus_addr,
  output logic [3:0]      o_bus_wstrb,
  output logic [XLEN-1:0] o_bus_wdata,
  input  logic            i_bus_ready,
  input  logic [XLEN-1:0] i_bus_rdata
);

  localparam bit          TO_EN   = (TIMEOUT != 0);
  localparam logic [31:0] TO_LAST = 32'(TIMEOUT - 1);

  lsu_state_e      state_q, state_d;
  logic            valid_q, valid_d, we_q, we_d, done_q, done_d, fault_q, fault_d;
  logic [XLEN-1:0] addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
  logic [3:0]      wstrb_q, wstrb_d;
  logic [31:0]     cnt_q, cnt_d;
  logic [2:0]      fmt_q, fmt_d;
  logic [1:0]      lo_q, lo_d;

  logic            req, bad;
  logic [3:0]      st_wstrb;
  logic [XLEN-1:0] st_wdata, ld_data;

  assign req = i_bus_r_en | i_bus_w_en;

  lsu_align #(.XLEN(XLEN)) u_align (
    .st_fmt_i  (i_bus_fmt),
    .st_lo_i   (i_addr[1:0]),
    .st_data_i (i_wdata),
    .r_en_i    (i_bus_r_en),
    .w_en_i    (i_bus_w_en),
    .wstrb_o   (st_wstrb),
    .wdata_o   (st_wdata),
    .bad_o     (bad),
    .ld_fmt_i  (fmt_q),
    .ld_lo_i   (lo_q),
    .ld_word_i (i_bus_rdata),
    .ld_data_o (ld_data)
  );

  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wstrb_d = wstrb_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    cnt_d   = cnt_q;
    fmt_d   = fmt_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    fault_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (req) begin
          if (bad) begin
            fault_d = 1'b1;
            state_d = RESP;
          end else begin
            valid_d = 1'b1;
            we_d    = i_bus_w_en;
            addr_d  = {i_addr[XLEN-1:2], 2'b00};
            wstrb_d = i_bus_w_en ? st_wstrb : 4'b0000;
            wdata_d = st_wdata;
            fmt_d   = i_bus_fmt;
            lo_d    = i_addr[1:0];
            cnt_d   = 32'd0;
            state_d = ACCESS;
          end
        end
      end
      ACCESS: begin
        // Ready has priority over a timeout landing in the same cycle.
        if (i_bus_ready) begin
          valid_d = 1'b0;
          if (!we_q) rdata_d = ld_data;
          done_d  = 1'b1;
          state_d = RESP;
        end else if (TO_EN && (cnt_q == TO_LAST)) begin
          valid_d = 1'b0;
          fault_d = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= IDLE;
      valid_q <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wstrb_q <= 4'b0000;
      wdata_q <= '0;
      rdata_q <= '0;
      cnt_q   <= 32'd0;
      fmt_q   <= 3'b000;
      lo_q    <= 2'b00;
      done_q  <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wstrb_q <= wstrb_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      cnt_q   <= cnt_d;
      fmt_q   <= fmt_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
      fault_q <= fault_d;
    end
  end

  assign o_rdata     = rdata_q;
  assign o_done      = done_q;
  assign o_fault     = fault_q;
  assign o_stall     = req & ~done_q & ~fault_q;
  assign o_bus_valid = valid_q;
  assign o_bus_we    = we_q;
  assign o_bus_addr  = addr_q;
  assign o_bus_wstrb = wstrb_q;
  assign o_bus_wdata = wdata_q;

endmodule

// File: tb/tb_lsu.sv
// Scoreboard bench for lsu: directed accesses push expected bus requests and
// responses; independent monitors compare whenever the DUT presents them.
module tb_lsu;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic [2:0]  i_bus_fmt;
  logic        i_bus_r_en, i_bus_w_en;
  logic [31:0] i_addr, i_wdata;
  logic [31:0] o_rdata;
  logic        o_done, o_fault, o_stall;
  logic        o_bus_valid, o_bus_we;
  logic [31:0] o_bus_addr, o_bus_wdata;
  logic [3:0]  o_bus_wstrb;
  logic        i_bus_ready;
  logic [31:0] i_bus_rdata;

  lsu #(.XLEN(32), .TIMEOUT(4)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_bus_fmt(i_bus_fmt),
    .i_bus_r_en(i_bus_r_en), .i_bus_w_en(i_bus_w_en),
    .i_addr(i_addr), .i_wdata(i_wdata), .o_rdata(o_rdata),
    .o_done(o_done), .o_fault(o_fault), .o_stall(o_stall),
    .o_bus_valid(o_bus_valid), .o_bus_we(o_bus_we), .o_bus_addr(o_bus_addr),
    .o_bus_wstrb(o_bus_wstrb), .o_bus_wdata(o_bus_wdata),
    .i_bus_ready(i_bus_ready), .i_bus_rdata(i_bus_rdata)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  strb;
    logic [31:0] wd;
  } bus_t;

  typedef struct {
    bit          fault;
    bit          chk_rd;
    logic [31:0] rd;
  } rsp_t;

  bus_t bus_q[$];
  rsp_t rsp_q[$];

  int total = 0;
  int bad   = 0;

  int          cur_waits = 0;
  logic [31:0] cur_rdata = '0;
  int          wcnt      = 0;
  bit          force_ready = 1'b0;
  logic        prev_valid  = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Bus slave: inserts cur_waits wait cycles, then accepts with cur_rdata.
  always @(negedge i_clk) begin
    if (o_bus_valid) begin
      if (wcnt >= cur_waits) begin
        i_bus_ready = 1'b1;
        i_bus_rdata = cur_rdata;
      end else begin
        i_bus_ready = 1'b0;
        wcnt++;
      end
    end else begin
      i_bus_ready = force_ready;
      i_bus_rdata = 32'h5555_AAAA;
      wcnt = 0;
    end
  end

  // Bus request monitor: every valid cycle must match the pending request.
  always @(negedge i_clk) begin
    if (o_bus_valid) begin
      if (bus_q.size() == 0) begin
        chk("unexpected_bus_valid", 32'(o_bus_valid), 32'd0);
      end else begin
        chk("bus_addr", o_bus_addr, bus_q[0].addr);
        chk("bus_we", 32'(o_bus_we), 32'(bus_q[0].we));
        chk("bus_wstrb", 32'(o_bus_wstrb), 32'(bus_q[0].strb));
        if (bus_q[0].we) chk("bus_wdata", o_bus_wdata, bus_q[0].wd);
      end
    end else if (prev_valid && bus_q.size() != 0) begin
      void'(bus_q.pop_front());
    end
    prev_valid = o_bus_valid;
  end

  // Response monitor: each done/fault pulse consumes one expected response.
  always @(negedge i_clk) begin
    if (!i_rst && (o_done || o_fault)) begin
      if (rsp_q.size() == 0) begin
        chk("unexpected_response", {30'd0, o_done, o_fault}, 32'd0);
      end else begin
        rsp_t e;
        e = rsp_q.pop_front();
        chk("rsp_done", 32'(o_done), 32'(!e.fault));
        chk("rsp_fault", 32'(o_fault), 32'(e.fault));
        if (e.chk_rd) chk("rsp_rdata", o_rdata, e.rd);
      end
    end
  end

  task automatic run(input string nm, input logic [2:0] fmt, input logic r, input logic w,
                     input logic [31:0] addr, input logic [31:0] wd, input int waits,
                     input logic [31:0] brd, input bit fault, input logic [31:0] exp_rd,
                     input logic [3:0] exp_strb, input logic [31:0] exp_wd,
                     input int exp_lat, input int exp_vcnt);
    int lat, vcnt, vfirst;
    bus_t b;
    rsp_t e;
    if (!fault || waits > 100) begin
      b.addr = {addr[31:2], 2'b00}; b.we = w; b.strb = exp_strb; b.wd = exp_wd;
      bus_q.push_back(b);
    end
    e.fault = fault; e.chk_rd = r && !fault; e.rd = exp_rd;
    rsp_q.push_back(e);
    @(negedge i_clk);
    i_bus_fmt = fmt; i_bus_r_en = r; i_bus_w_en = w; i_addr = addr; i_wdata = wd;
    cur_waits = waits; cur_rdata = brd;
    #1 chk({nm, "_stall_c0"}, 32'(o_stall), 32'd1);
    lat = -1; vcnt = 0; vfirst = -1;
    for (int k = 1; k <= 300; k++) begin
      @(negedge i_clk);
      if (o_bus_valid) begin
        vcnt++;
        if (vfirst < 0) vfirst = k;
      end
      if (o_done || o_fault) begin
        lat = k;
        #1 chk({nm, "_stall_end"}, 32'(o_stall), 32'd0);
        break;
      end
      if (k < exp_lat) #1 chk({nm, "_stall_wait"}, 32'(o_stall), 32'd1);
    end
    i_bus_r_en = 1'b0; i_bus_w_en = 1'b0;
    chk({nm, "_latency"}, 32'(lat), 32'(exp_lat));
    chk({nm, "_valid_cycles"}, 32'(vcnt), 32'(exp_vcnt));
    if (exp_vcnt > 0) chk({nm, "_valid_first"}, 32'(vfirst), 32'd1);
    @(negedge i_clk);
  endtask

  initial begin
    i_rst = 1'b1;
    i_bus_fmt = 3'b000; i_bus_r_en = 1'b0; i_bus_w_en = 1'b0;
    i_addr = '0; i_wdata = '0; i_bus_ready = 1'b0; i_bus_rdata = '0;
    repeat (2) @(negedge i_clk);
    chk("rst_valid", 32'(o_bus_valid), 32'd0);
    chk("rst_we", 32'(o_bus_we), 32'd0);
    chk("rst_wstrb", 32'(o_bus_wstrb), 32'd0);
    chk("rst_done_fault", {30'd0, o_done, o_fault}, 32'd0);
    chk("rst_addr", o_bus_addr, 32'd0);
    chk("rst_wdata", o_bus_wdata, 32'd0);
    chk("rst_rdata", o_rdata, 32'd0);
    i_rst = 1'b0;
    @(negedge i_clk);

    // name fmt r w addr wdata waits busrdata fault exp_rd strb exp_wd lat vcnt
    run("sw",   3'b010, 0, 1, 32'h100, 32'hDEADBEEF, 0, 32'h0, 0, 32'h0, 4'b1111, 32'hDEADBEEF, 2, 1);
    run("sb3",  3'b000, 0, 1, 32'h103, 32'h000000A5, 0, 32'h0, 0, 32'h0, 4'b1000, 32'hA5A5A5A5, 2, 1);
    run("sb1",  3'b000, 0, 1, 32'h101, 32'h00000012, 1, 32'h0, 0, 32'h0, 4'b0010, 32'h12121212, 3, 2);
    run("sh2",  3'b001, 0, 1, 32'h102, 32'h0000BEEF, 0, 32'h0, 0, 32'h0, 4'b1100, 32'hBEEFBEEF, 2, 1);
    run("lb",   3'b000, 1, 0, 32'h102, 32'h0, 3, 32'h1280FF34, 0, 32'hFFFFFF80, 4'b0000, 32'h0, 5, 4);
    run("lbu",  3'b100, 1, 0, 32'h102, 32'h0, 3, 32'h1280FF34, 0, 32'h00000080, 4'b0000, 32'h0, 5, 4);
    run("lh2",  3'b001, 1, 0, 32'h102, 32'h0, 3, 32'h1280FF34, 0, 32'h00001280, 4'b0000, 32'h0, 5, 4);
    run("lh0",  3'b001, 1, 0, 32'h100, 32'h0, 0, 32'h1280FF34, 0, 32'hFFFFFF34, 4'b0000, 32'h0, 2, 1);
    run("lhu0", 3'b101, 1, 0, 32'h100, 32'h0, 0, 32'h1280FF34, 0, 32'h0000FF34, 4'b0000, 32'h0, 2, 1);
    run("lw",   3'b010, 1, 0, 32'h104, 32'h0, 1, 32'h12345678, 0, 32'h12345678, 4'b0000, 32'h0, 3, 2);
    run("lw_mis",  3'b010, 1, 0, 32'h101, 32'h0, 0, 32'h0, 1, 32'h0, 4'b0000, 32'h0, 1, 0);
    run("lh_mis",  3'b001, 1, 0, 32'h103, 32'h0, 0, 32'h0, 1, 32'h0, 4'b0000, 32'h0, 1, 0);
    run("fmt011",  3'b011, 1, 0, 32'h100, 32'h0, 0, 32'h0, 1, 32'h0, 4'b0000, 32'h0, 1, 0);
    run("rw_both", 3'b010, 1, 1, 32'h100, 32'h0, 0, 32'h0, 1, 32'h0, 4'b0000, 32'h0, 1, 0);
    run("timeout", 3'b010, 1, 0, 32'h108, 32'h0, 1000, 32'h0, 1, 32'h0, 4'b0000, 32'h0, 5, 4);
    run("after_to", 3'b010, 1, 0, 32'h10C, 32'h0, 0, 32'hCAFEF00D, 0, 32'hCAFEF00D, 4'b0000, 32'h0, 2, 1);

    // Ready while idle must not produce any response.
    force_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge i_clk);
      #1 chk("idle_ready", {30'd0, o_done, o_fault}, 32'd0);
    end
    force_ready = 1'b0;

    // Reset in the middle of an access.
    begin
      bus_t b;
      b.addr = 32'h200; b.we = 1'b0; b.strb = 4'b0000; b.wd = 32'h0;
      bus_q.push_back(b);
    end
    @(negedge i_clk);
    i_bus_fmt = 3'b010; i_bus_r_en = 1'b1; i_bus_w_en = 1'b0; i_addr = 32'h200;
    cur_waits = 1000;
    @(negedge i_clk);
    chk("midrst_valid_before", 32'(o_bus_valid), 32'd1);
    @(negedge i_clk);
    #2 i_rst = 1'b1;
    #1 chk("midrst_valid_async", 32'(o_bus_valid), 32'd0);
    chk("midrst_no_rsp", {30'd0, o_done, o_fault}, 32'd0);
    i_bus_r_en = 1'b0;
    @(negedge i_clk);
    i_rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge i_clk);
      #1 chk("midrst_quiet", {29'd0, o_bus_valid, o_done, o_fault}, 32'd0);
    end
    run("post_rst", 3'b000, 1, 0, 32'h201, 32'h0, 0, 32'h00007F00, 0, 32'h0000007F, 4'b0000, 32'h0, 2, 1);

    repeat (3) @(negedge i_clk);
    chk("bus_q_empty", 32'(bus_q.size()), 32'd0);
    chk("rsp_q_empty", 32'(rsp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
